// File: rtl/nibble_serial_cla_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice is reused across WIDTH/4
// clock cycles, with valid/ready handshakes on both the operand and result sides.
module nibble_serial_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
    logic               carry_reg, cout_reg, ovf_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic [3:0] a_nibs [NIB];
    logic [3:0] b_nibs [NIB];
    logic [3:0] p, g, nib_sum;
    logic [4:0] c;
    logic       last_nib;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib_split
            assign a_nibs[gi] = a_reg[4*gi +: 4];
            assign b_nibs[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    assign p = a_nibs[idx_reg] ^ b_nibs[idx_reg];
    assign g = a_nibs[idx_reg] & b_nibs[idx_reg];

    // Flat two-level lookahead so no carry ripples inside the nibble.
    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign nib_sum  = p ^ c[3:0];
    assign last_nib = (idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_i)  state_next = RUN;
            RUN:     if (last_nib) state_next = DONE;
            DONE:    if (ready_i)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        a_reg     <= a_i;
                        b_reg     <= b_i;
                        carry_reg <= cin_i;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (idx_reg == IDX_W'(k)) sum_reg[4*k +: 4] <= nib_sum;
                    end
                    carry_reg <= c[4];
                    idx_reg   <= idx_reg + IDX_W'(1);
                    if (last_nib) begin
                        cout_reg <= c[4];
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        ovf_reg  <= c[3] ^ c[4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign valid_o = (state_reg == DONE);
    assign sum_o   = sum_reg;
    assign cout_o  = cout_reg;
    assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench for nibble_serial_cla_adder: a 32-bit and an 8-bit instance
// are compared against plain a+b+cin arithmetic with signed-overflow rules.
module tb_nibble_serial_cla_adder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] a_i, b_i, sum_o;
    logic        cin_i, valid_i, ready_o, cout_o, ovf_o, valid_o, ready_i;
    logic [7:0]  a8_i, b8_i, sum8_o;
    logic        cin8_i, valid8_i, ready8_o, cout8_o, ovf8_o, valid8_o, ready8_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_cla_adder #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
        .valid_i(valid_i), .ready_o(ready_o), .sum_o(sum_o), .cout_o(cout_o),
        .ovf_o(ovf_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    nibble_serial_cla_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .a_i(a8_i), .b_i(b8_i), .cin_i(cin8_i),
        .valid_i(valid8_i), .ready_o(ready8_o), .sum_o(sum8_o), .cout_o(cout8_o),
        .ovf_o(ovf8_o), .valid_o(valid8_o), .ready_i(ready8_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 32-bit transaction: accept, measure latency, check result, optionally
    // stall the result for 'hold' cycles while disturbing the input side.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int hold, input bit toggle, input bit verbose);
        logic [32:0] exp;
        logic        eovf;
        int          n;
        exp  = {1'b0, a} + {1'b0, b} + 33'(cin);
        eovf = (a[31] == b[31]) && (exp[31] != a[31]);
        a_i = a; b_i = b; cin_i = cin; valid_i = 1'b1; ready_i = (hold == 0);
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++; $display("FAIL op32_ready_before_accept: got %b, expected 1", ready_o);
        end
        tick();
        a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
        n = 0;
        while (valid_o !== 1'b1 && n < 40) begin
            valid_i = toggle ? 1'($urandom) : 1'b0;
            tick();
            n++;
        end
        n_cmp++;
        if (n != 8) begin
            n_bad++; $display("FAIL op32_latency: got %0d cycles, expected 8", n);
            return;
        end
        n_cmp++;
        if ({cout_o, sum_o} !== exp || ovf_o !== eovf) begin
            n_bad++;
            $display("FAIL op32_result a=%h b=%h cin=%0b: got cout=%0b sum=%h ovf=%0b, expected cout=%0b sum=%h ovf=%0b",
                     a, b, cin, cout_o, sum_o, ovf_o, exp[32], exp[31:0], eovf);
        end
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                valid_i = 1'($urandom); a_i = $urandom; b_i = $urandom;
            end
            tick();
            n_cmp++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || {cout_o, sum_o} !== exp || ovf_o !== eovf) begin
                n_bad++;
                $display("FAIL op32_hold: got valid=%b ready=%b sum=%h cout=%b ovf=%b, expected valid=1 ready=0 sum=%h cout=%b ovf=%b",
                         valid_o, ready_o, sum_o, cout_o, ovf_o, exp[31:0], exp[32], eovf);
            end
        end
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || {cout_o, sum_o} !== exp || ovf_o !== eovf) begin
            n_bad++;
            $display("FAIL op32_handshake: got ready=%b valid=%b sum=%h, expected ready=1 valid=0 sum=%h",
                     ready_o, valid_o, sum_o, exp[31:0]);
        end
        if (verbose)
            $display("op32 a=%h b=%h cin=%0b -> sum=%h cout=%0b ovf=%0b", a, b, cin, sum_o, cout_o, ovf_o);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int hold);
        logic [8:0] exp;
        logic       eovf;
        int         n;
        exp  = {1'b0, a} + {1'b0, b} + 9'(cin);
        eovf = (a[7] == b[7]) && (exp[7] != a[7]);
        a8_i = a; b8_i = b; cin8_i = cin; valid8_i = 1'b1; ready8_i = (hold == 0);
        n_cmp++;
        if (ready8_o !== 1'b1) begin
            n_bad++; $display("FAIL op8_ready_before_accept: got %b, expected 1", ready8_o);
        end
        tick();
        a8_i = 8'($urandom); b8_i = 8'($urandom);
        n = 0;
        while (valid8_o !== 1'b1 && n < 20) begin
            valid8_i = 1'($urandom);
            tick();
            n++;
        end
        n_cmp++;
        if (n != 2) begin
            n_bad++; $display("FAIL op8_latency: got %0d cycles, expected 2", n);
            return;
        end
        n_cmp++;
        if ({cout8_o, sum8_o} !== exp || ovf8_o !== eovf) begin
            n_bad++;
            $display("FAIL op8_result a=%h b=%h cin=%0b: got cout=%0b sum=%h ovf=%0b, expected cout=%0b sum=%h ovf=%0b",
                     a, b, cin, cout8_o, sum8_o, ovf8_o, exp[8], exp[7:0], eovf);
        end
        for (int i = 0; i < hold; i++) begin
            valid8_i = 1'($urandom);
            tick();
            n_cmp++;
            if (valid8_o !== 1'b1 || ready8_o !== 1'b0 || {cout8_o, sum8_o} !== exp) begin
                n_bad++;
                $display("FAIL op8_hold: got valid=%b ready=%b sum=%h, expected valid=1 ready=0 sum=%h",
                         valid8_o, ready8_o, sum8_o, exp[7:0]);
            end
        end
        ready8_i = 1'b1;
        tick();
        valid8_i = 1'b0;
        n_cmp++;
        if (ready8_o !== 1'b1 || valid8_o !== 1'b0) begin
            n_bad++;
            $display("FAIL op8_handshake: got ready=%b valid=%b, expected ready=1 valid=0", ready8_o, valid8_o);
        end
        $display("op8 a=%h b=%h cin=%0b -> sum=%h cout=%0b ovf=%0b", a, b, cin, sum8_o, cout8_o, ovf8_o);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        a_i = '0; b_i = '0; cin_i = 0; valid_i = 0; ready_i = 0;
        a8_i = '0; b8_i = '0; cin8_i = 0; valid8_i = 0; ready8_i = 0;
        tick(); tick();
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || sum_o !== 32'h0 || cout_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset32: got ready=%b valid=%b sum=%h cout=%b ovf=%b, expected 1 0 00000000 0 0",
                     ready_o, valid_o, sum_o, cout_o, ovf_o);
        end
        n_cmp++;
        if (ready8_o !== 1'b1 || valid8_o !== 1'b0 || sum8_o !== 8'h0 || cout8_o !== 1'b0 || ovf8_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset8: got ready=%b valid=%b sum=%h cout=%b ovf=%b, expected 1 0 00 0 0",
                     ready8_o, valid8_o, sum8_o, cout8_o, ovf8_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0, 1);
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 0, 1);
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 0, 1);
        op32(32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 1);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 1);
        op32(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0, 1);
        op32(32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 0, 0, 1);
        op8(8'h7F, 8'h01, 1'b0, 0);
        op8(8'hFF, 8'h00, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        op32(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 5, 1, 1);
        tick();
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL backpressure_single_handshake: got valid=%b ready=%b, expected valid=0 ready=1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset_run();
        int seen;
        a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; cin_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick(); tick(); tick();
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || sum_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_in_run: got valid=%b ready=%b sum=%h, expected valid=0 ready=1 sum=00000000",
                     valid_o, ready_o, sum_o);
        end
        tick();
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL reset_no_valid_pulse: got %0d valid cycles, expected 0", seen);
        end
        op32(32'h0000_0003, 32'h0000_0005, 1'b0, 0, 0, 1);
    endtask

    task automatic test_random32();
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) tick();
            op32($urandom, $urandom, 1'($urandom), $urandom_range(0, 3), 1, 1);
        end
    endtask

    task automatic test_random8();
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) tick();
            op8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_run();
        test_random32();
        test_random8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
